// File: rtl/tick_sched_if.sv
// ---------------------------------------------------------------------------
// tick_sched_if
// Control/status bundle between the top-level control logic (master) and the
// tick scheduler (slave).
//   start     master->slave  request to latch div_val/burst and begin running
//   stop      master->slave  abort a running sequence
//   div_val   master->slave  tick period in clk cycles (0 behaves as 1)
//   burst     master->slave  ticks to issue, 0 = free-run
//   busy      slave->master  high while running or finishing a burst
//   tick      slave->master  one-cycle enable pulse
//   tick_num  slave->master  ticks issued since the last start
//   done      slave->master  one-cycle pulse after the final burst tick
//   slow_out  slave->master  square wave toggled per tick (optional feature)
// ---------------------------------------------------------------------------
interface tick_sched_if #(
    parameter int DIV_W = 28,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div_val;
    logic [CNT_W-1:0] burst;
    logic             busy;
    logic             tick;
    logic [CNT_W-1:0] tick_num;
    logic             done;
    logic             slow_out;

    modport master (
        output start, stop, div_val, burst,
        input  busy, tick, tick_num, done, slow_out
    );

    modport slave (
        input  start, stop, div_val, burst,
        output busy, tick, tick_num, done, slow_out
    );
endinterface

// File: rtl/tick_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tick_sched_ctrl
// Programmable run/stop tick source for logic clocked by enables. On start it
// latches a divide period and a burst length, then issues registered one-cycle
// tick pulses every period cycles until stopped or the burst is exhausted.
//
// Ports
//   clk   system clock, all state on the rising edge
//   rst   asynchronous, active-high reset
//   bus   tick_sched_if.slave: start/stop/div_val/burst in,
//         busy/tick/tick_num/done/slow_out out
//
// Parameters
//   DIV_W  width of the divide period
//   CNT_W  width of the burst length and tick counter
//
// Configuration macro
//   TICK_SQUARE_OUT_EN  when defined, slow_out toggles on every tick and is
//                       cleared on start; otherwise slow_out is constant 0.
// ---------------------------------------------------------------------------
module tick_sched_ctrl #(
    parameter int DIV_W = 28,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    tick_sched_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] period;
    logic [CNT_W-1:0] blen;
    logic [CNT_W-1:0] tick_num_r;
    logic             tick_r;
    logic             done_r;
    logic             busy_r;

    logic             start_take;
    logic             tick_set;
    logic             last_cnt;
    logic [CNT_W-1:0] next_num;
    logic [DIV_W-1:0] div_eff;

    // A period of 0 would never wrap, so it is promoted to 1.
    assign div_eff    = (bus.div_val == '0) ? DIV_W'(1) : bus.div_val;
    assign last_cnt   = (cnt == period - DIV_W'(1));
    assign next_num   = tick_num_r + CNT_W'(1);
    assign start_take = (state == ST_IDLE) && bus.start;
    // stop outranks a tick falling on the same edge
    assign tick_set   = (state == ST_RUN) && !bus.stop && last_cnt;

    // Main sequencer. DONE spans two cycles: the first carries the final tick,
    // the second carries the done pulse, after which the block returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            period     <= '0;
            blen       <= '0;
            tick_num_r <= '0;
            tick_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        period     <= div_eff;
                        blen       <= bus.burst;
                        cnt        <= '0;
                        tick_num_r <= '0;
                        busy_r     <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        cnt    <= '0;
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (last_cnt) begin
                        cnt        <= '0;
                        tick_r     <= 1'b1;
                        tick_num_r <= next_num;
                        if ((blen != '0) && (next_num == blen)) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!done_r) begin
                        done_r <= 1'b1;
                    end else begin
                        cnt    <= '0;
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    cnt    <= '0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TICK_SQUARE_OUT_EN
    logic slow_r;

    // Square wave: flips on every tick so a full period spans two ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slow_r <= 1'b0;
        end else if (start_take) begin
            slow_r <= 1'b0;
        end else if (tick_set) begin
            slow_r <= ~slow_r;
        end
    end

    assign bus.slow_out = slow_r;
`else
    logic unused_ok;
    assign unused_ok    = start_take ^ tick_set;
    assign bus.slow_out = 1'b0;
`endif

    assign bus.busy     = busy_r;
    assign bus.tick     = tick_r;
    assign bus.tick_num = tick_num_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tick_sched_ctrl
// Self-checking bench for tick_sched_ctrl. Each run ("episode") is described
// by period, burst, optional stop edge and disturbance flags; the expected
// outputs for every edge are derived arithmetically from those numbers.
// ---------------------------------------------------------------------------
module tb_tick_sched_ctrl;

    localparam int DIV_W = 4;
    localparam int CNT_W = 8;

    typedef struct {
        int divIn;
        int burstIn;
        int stopAt;
        bit disturb;
        bit startStop;
        int expTicks;
        int expDone;
        int expBusy;
        int expNum;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tick_sched_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    tick_sched_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // compare one value and log a failure line on mismatch
    task automatic checkOutput(input string name, input int n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s edge=%0d got=%0d want=%0d", name, n, act, exp);
        end
    endtask

    // One complete start..idle sequence. Edge 0 is the edge that samples start.
    // Expected outputs after edge n follow directly from period p, burst b and
    // stop edge s: ticks land on multiples of p, capped by b and cut off by s.
    task automatic applyStimulus(input int divIn, input int burstIn, input int stopAt,
                                 input bit disturb, input bit startStop,
                                 output int nTicks, output int nDone,
                                 output int nBusy, output int lastNum);
        int p;
        int idleEdge;
        int lim;
        int cntTicks;
        int expTick;
        int expDone;
        int expBusy;
        int expSlow;
        p        = (divIn == 0) ? 1 : divIn;
        idleEdge = (stopAt != 0) ? stopAt : burstIn * p + 2;
        nTicks   = 0;
        nDone    = 0;
        nBusy    = 0;
        lastNum  = 0;

        @(negedge clk);
        bus.start   = 1'b1;
        bus.stop    = startStop;
        bus.div_val = DIV_W'(divIn);
        bus.burst   = CNT_W'(burstIn);

        for (int n = 0; n <= idleEdge + 2; n++) begin
            @(negedge clk);
            lim = n;
            if (stopAt != 0 && lim > stopAt - 1) lim = stopAt - 1;
            cntTicks = lim / p;
            if (burstIn != 0 && cntTicks > burstIn) cntTicks = burstIn;
            expTick = (n >= 1 && (n % p) == 0 && (burstIn == 0 || n / p <= burstIn)
                       && (stopAt == 0 || n < stopAt)) ? 1 : 0;
            expDone = (stopAt == 0 && n == burstIn * p + 1) ? 1 : 0;
            expBusy = (n < idleEdge) ? 1 : 0;
`ifdef TICK_SQUARE_OUT_EN
            expSlow = cntTicks % 2;
`else
            expSlow = 0;
`endif
            checkOutput("tick", n, int'(bus.tick), expTick);
            checkOutput("done", n, int'(bus.done), expDone);
            checkOutput("busy", n, int'(bus.busy), expBusy);
            checkOutput("tick_num", n, int'(bus.tick_num), cntTicks % 256);
            checkOutput("slow_out", n, int'(bus.slow_out), expSlow);
            nTicks  += int'(bus.tick);
            nDone   += int'(bus.done);
            nBusy   += int'(bus.busy);
            lastNum  = int'(bus.tick_num);

            // inputs for edge n+1
            bus.stop  = (stopAt != 0 && n + 1 == stopAt);
            bus.start = disturb && (n + 1 < idleEdge) && ((n + 1) % 2 == 1);
            if (disturb) begin
                bus.div_val = DIV_W'($urandom);
                bus.burst   = CNT_W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   nTicks;
        int   nDone;
        int   nBusy;
        int   lastNum;

        total = 0;
        bad   = 0;

        //          div burst stop dist ss  ticks done busy num
        vecs[0] = '{4,  3,    0,   0,   0,  3,    1,   14,  3};
        vecs[1] = '{0,  2,    0,   0,   0,  2,    1,   4,   2};
        vecs[2] = '{3,  0,    9,   0,   0,  2,    0,   9,   2};
        vecs[3] = '{2,  4,    0,   1,   0,  4,    1,   10,  4};
        vecs[4] = '{1,  1,    0,   0,   1,  1,    1,   3,   1};
        vecs[5] = '{5,  0,    3,   0,   0,  0,    0,   3,   0};
        vecs[6] = '{4,  2,    8,   0,   0,  1,    0,   8,   1};
        vecs[7] = '{0,  0,    260, 0,   0,  259,  0,   260, 3};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.div_val = '0;
        bus.burst   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 0, int'(bus.busy), 0);
        checkOutput("rst_tick", 0, int'(bus.tick), 0);
        checkOutput("rst_done", 0, int'(bus.done), 0);
        checkOutput("rst_num", 0, int'(bus.tick_num), 0);
        checkOutput("rst_slow", 0, int'(bus.slow_out), 0);
        rst = 1'b0;

        // stop while idle must not start anything
        @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        checkOutput("idle_stop_busy", 0, int'(bus.busy), 0);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].divIn, vecs[i].burstIn, vecs[i].stopAt,
                          vecs[i].disturb, vecs[i].startStop,
                          nTicks, nDone, nBusy, lastNum);
            checkOutput("vec_ticks", i, nTicks, vecs[i].expTicks);
            checkOutput("vec_done", i, nDone, vecs[i].expDone);
            checkOutput("vec_busy", i, nBusy, vecs[i].expBusy);
            checkOutput("vec_num", i, lastNum, vecs[i].expNum);
        end

        // asynchronous reset in the middle of a run, period 5
        $display("[TB] async reset mid-run");
        @(negedge clk);
        bus.start   = 1'b1;
        bus.div_val = DIV_W'(5);
        bus.burst   = '0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("pre_rst_busy", 6, int'(bus.busy), 1);
        checkOutput("pre_rst_num", 6, int'(bus.tick_num), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 0, int'(bus.busy), 0);
        checkOutput("mid_rst_tick", 0, int'(bus.tick), 0);
        checkOutput("mid_rst_done", 0, int'(bus.done), 0);
        checkOutput("mid_rst_num", 0, int'(bus.tick_num), 0);
        checkOutput("mid_rst_slow", 0, int'(bus.slow_out), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_busy", 0, int'(bus.busy), 0);
        checkOutput("post_rst_tick", 0, int'(bus.tick), 0);

        // first run after reset behaves normally
        applyStimulus(4, 3, 0, 0, 0, nTicks, nDone, nBusy, lastNum);
        checkOutput("after_rst_ticks", 0, nTicks, 3);

        $display("[TB] randomized episodes");
        for (int r = 0; r < 25; r++) begin
            int d;
            int b;
            int p;
            int s;
            d = $urandom_range(0, 15);
            b = $urandom_range(0, 5);
            p = (d == 0) ? 1 : d;
            if (b == 0) s = $urandom_range(1, 40);
            else if ($urandom_range(0, 2) == 0) s = $urandom_range(1, b * p);
            else s = 0;
            applyStimulus(d, b, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          nTicks, nDone, nBusy, lastNum);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
